da2_arbiter: RTL and testbench

DA2_ARBITER -- requirements
Module: da2_arbiter

---
 rtl/da2_pkg.sv | 16 +
 rtl/da2_rr_pick.sv | 19 +
 rtl/da2_arbiter.sv | 139 +++++++++++++
 tb/tb_da2_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da2_pkg.sv
// Shared types and constants for the DA2 two-requester arbiter.
package da2_pkg;

    // Width of one DA2 channel sample.
    localparam int DA2_VW  = 12;
    // Number of requesters competing for the serializer.
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HOLDOFF
    } state_e;

endpackage

// File: rtl/da2_rr_pick.sv
// Round-robin winner select for two requesters. Purely combinational.
// When both requesters ask, the one that is not the current owner wins.
// A lone requester always wins.
module da2_rr_pick
    import da2_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               owner,
    output logic               valid,
    output logic               winner
);

    // Select the winner from the request vector and the previous owner.
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~owner : req[1];
    end

endmodule

// File: rtl/da2_arbiter.sv
// Two-requester arbiter in front of a DA2 serializer.
// It grants round-robin, latches the winner's sample pair and pulses
// dac_update. Once the serializer finishes, it acks the owner.
// An optional holdoff gap follows each transfer.
// Optional grant counters are built when DA2_ARBITER_STATS_EN is defined.
module da2_arbiter
    import da2_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 0,
    parameter int VW             = DA2_VW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [VW-1:0]      r0_value0,
    input  logic [VW-1:0]      r0_value1,
    input  logic [VW-1:0]      r1_value0,
    input  logic [VW-1:0]      r1_value1,
    output logic [NUM_REQ-1:0] ack,
    output logic [VW-1:0]      dac_value0,
    output logic [VW-1:0]      dac_value1,
    output logic               dac_update,
    input  logic               dac_busy,
    output logic               owner
`ifdef DA2_ARBITER_STATS_EN
    ,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1
`endif
);

    // The counter only ever holds HOLDOFF_CYCLES-1, so clog2 of the count is enough.
    localparam int HCW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [VW-1:0]   val0_q, val0_d;
    logic [VW-1:0]   val1_q, val1_d;
    logic            upd_q, upd_d;
    logic [HCW-1:0]  hcnt_q, hcnt_d;
    logic            pick_valid;
    logic            pick_winner;

    da2_rr_pick u_pick (
        .req    (req),
        .owner  (owner_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Next-state, datapath load and ack decode.
    // upd_q is high only in the first WAIT_DONE cycle.
    // That is the cycle in which dac_busy has not risen yet, so it is ignored there.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        val0_d  = val0_q;
        val1_d  = val1_q;
        upd_d   = 1'b0;
        hcnt_d  = hcnt_q;
        ack     = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    val0_d  = pick_winner ? r1_value0 : r0_value0;
                    val1_d  = pick_winner ? r1_value1 : r0_value1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                upd_d   = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!upd_q && !dac_busy) begin
                    ack[owner_q] = 1'b1;
                    if (HOLDOFF_CYCLES > 0) begin
                        hcnt_d  = HCW'(HOLDOFF_CYCLES - 1);
                        state_d = HOLDOFF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (hcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset drops any transfer in flight without an ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            val0_q  <= '0;
            val1_q  <= '0;
            upd_q   <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            val0_q  <= val0_d;
            val1_q  <= val1_d;
            upd_q   <= upd_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign dac_value0 = val0_q;
    assign dac_value1 = val1_q;
    assign dac_update = upd_q;
    assign owner      = owner_q;

`ifdef DA2_ARBITER_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Per-requester completed-transfer counters. They wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (ack[0]) cnt0_q <= cnt0_q + 16'd1;
            if (ack[1]) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_da2_arbiter.sv
// Scoreboard bench for da2_arbiter. Stimulus pushes expected grants and acks.
// Negedge monitors pop the queues and compare.
// A second instance with HOLDOFF_CYCLES=5 is used for the holdoff gap.
module tb_da2_arbiter;

    localparam int VW    = 12;
    localparam int SHIFT = 6;

    typedef struct packed {
        logic          own;
        logic [VW-1:0] v0;
        logic [VW-1:0] v1;
    } grant_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req, ack;
    logic [VW-1:0] r0v0, r0v1, r1v0, r1v1, dv0, dv1;
    logic          upd, busy, own;

    logic [1:0]    req_h, ack_h;
    logic [VW-1:0] dv0_h, dv1_h;
    logic          upd_h, busy_h, own_h;

`ifdef DA2_ARBITER_STATS_EN
    logic [15:0] gc0, gc1, gc0_h, gc1_h;
    int st0, st1;
`endif

    da2_arbiter #(.HOLDOFF_CYCLES(0), .VW(VW)) u_dut (
        .clk(clk), .rst(rst), .req(req),
        .r0_value0(r0v0), .r0_value1(r0v1), .r1_value0(r1v0), .r1_value1(r1v1),
        .ack(ack), .dac_value0(dv0), .dac_value1(dv1), .dac_update(upd),
        .dac_busy(busy), .owner(own)
`ifdef DA2_ARBITER_STATS_EN
        , .grant_cnt0(gc0), .grant_cnt1(gc1)
`endif
    );

    da2_arbiter #(.HOLDOFF_CYCLES(5), .VW(VW)) u_ho (
        .clk(clk), .rst(rst), .req(req_h),
        .r0_value0(r0v0), .r0_value1(r0v1), .r1_value0(r1v0), .r1_value1(r1v1),
        .ack(ack_h), .dac_value0(dv0_h), .dac_value1(dv1_h), .dac_update(upd_h),
        .dac_busy(busy_h), .owner(own_h)
`ifdef DA2_ARBITER_STATS_EN
        , .grant_cnt0(gc0_h), .grant_cnt1(gc1_h)
`endif
    );

    // Serializer models: busy for SHIFT cycles starting the cycle after dac_update.
    int bcnt = 0, bcnt_h = 0;
    always @(posedge clk) begin
        if (upd) bcnt <= SHIFT; else if (bcnt > 0) bcnt <= bcnt - 1;
        if (upd_h) bcnt_h <= SHIFT; else if (bcnt_h > 0) bcnt_h <= bcnt_h - 1;
    end
    assign busy   = (bcnt != 0);
    assign busy_h = (bcnt_h != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    grant_t     gq[$];
    logic [1:0] aq[$];
    int ack0_n = 0, ack1_n = 0, last_upd_cyc = 0, last_ack_cyc = 0;
    bit gap_chk = 1'b0;

    task automatic expect_grant(input logic o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                input logic [1:0] ak);
        grant_t g;
        g.own = o; g.v0 = a; g.v1 = b;
        gq.push_back(g);
        if (ak != 2'b00) aq.push_back(ak);
    endtask

    // Main monitor: every dac_update and every ack must match the head of its queue.
    always @(negedge clk) begin
        grant_t     g;
        logic [1:0] a;
        if (rst) begin
            if (upd) begin
                if (gap_chk) check("b2b_gap", cyc - (last_ack_cyc + 1), 2);
                last_upd_cyc = cyc;
                if (gq.size() == 0) check("unexp_update", 1, 0);
                else begin
                    g = gq.pop_front();
                    check("owner", int'(own), int'(g.own));
                    check("dac_value0", int'(dv0), int'(g.v0));
                    check("dac_value1", int'(dv1), int'(g.v1));
                end
            end
            if (ack != 2'b00) begin
                last_ack_cyc = cyc;
                if (ack[0]) ack0_n++;
                if (ack[1]) ack1_n++;
`ifdef DA2_ARBITER_STATS_EN
                if (ack[0]) st0++;
                if (ack[1]) st1++;
`endif
                check("ack_onehot", $countones(ack), 1);
                if (aq.size() == 0) check("unexp_ack", int'(ack), 0);
                else begin
                    a = aq.pop_front();
                    check("ack", int'(ack), int'(a));
                end
            end
        end
    end

    // Holdoff instance monitor: gap from the ack edge to the next dac_update edge is 5+2.
    // Acks alternate 0,1,0,...
    int h_ack_cyc = 0, h_upd_n = 0, h_ack_n = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (upd_h) begin
                h_upd_n++;
                if (h_upd_n >= 2) check("holdoff_gap", cyc - (h_ack_cyc + 1), 7);
            end
            if (ack_h != 2'b00) begin
                h_ack_cyc = cyc;
                check("holdoff_ack", int'(ack_h), (h_ack_n % 2 == 0) ? 1 : 2);
                h_ack_n++;
            end
        end
    end

    task automatic wait_acks(input int target, input string nm);
        int n;
        n = 0;
        while ((ack0_n + ack1_n) < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        check({nm, "_ack_seen"}, ((ack0_n + ack1_n) >= target) ? 1 : 0, 1);
        #1;
    endtask

    task automatic wait_grant(input string nm);
        int n;
        n = 0;
        while (gq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check({nm, "_update_seen"}, (gq.size() == 0) ? 1 : 0, 1);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, b0, b1, base;
        rst = 1'b0; req = 2'b00; req_h = 2'b00;
        r0v0 = '0; r0v1 = '0; r1v0 = '0; r1v1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_update", int'(upd), 0);
        check("reset_ack", int'(ack), 0);
        check("reset_value0", int'(dv0), 0);
        check("reset_value1", int'(dv1), 0);
        check("reset_owner", int'(own), 1);
        @(posedge clk); #1 rst = 1'b1;
        idle(2);

        // Single requester 0: two-cycle latency, values latched, one ack.
        r0v0 = 12'hAAA; r0v1 = 12'hFFF;
        expect_grant(1'b0, 12'hAAA, 12'hFFF, 2'b01);
        b0 = ack0_n; base = ack0_n + ack1_n;
        c0 = cyc; req[0] = 1'b1;
        wait_acks(base + 1, "single0");
        req[0] = 1'b0;
        check("latency", last_upd_cyc - c0, 2);
        idle(4);
        check("single0_ack_count", ack0_n - b0, 1);

        // Lone requester 0 again wins even though it already owns.
        r0v0 = 12'h123; r0v1 = 12'h456;
        expect_grant(1'b0, 12'h123, 12'h456, 2'b01);
        base = ack0_n + ack1_n; req[0] = 1'b1;
        wait_acks(base + 1, "repeat0");
        req[0] = 1'b0;
        r0v0 = 12'h777; r0v1 = 12'h888;
        idle(3);
        check("hold_value0", int'(dv0), 12'h123);
        check("hold_value1", int'(dv1), 12'h456);

        // Lone requester 1.
        r1v0 = 12'h0F0; r1v1 = 12'h00F;
        expect_grant(1'b1, 12'h0F0, 12'h00F, 2'b10);
        base = ack0_n + ack1_n; req[1] = 1'b1;
        wait_acks(base + 1, "single1");
        req[1] = 1'b0;
        idle(3);

        // Both requesters held from reset: grants 0,1,0,1 back to back.
        #1 rst = 1'b0;
`ifdef DA2_ARBITER_STATS_EN
        st0 = 0; st1 = 0;
`endif
        idle(1);
        rst = 1'b1;
        r0v0 = 12'h111; r0v1 = 12'h222; r1v0 = 12'h333; r1v1 = 12'h444;
        expect_grant(1'b0, 12'h111, 12'h222, 2'b01);
        expect_grant(1'b1, 12'h333, 12'h444, 2'b10);
        expect_grant(1'b0, 12'h111, 12'h222, 2'b01);
        expect_grant(1'b1, 12'h333, 12'h444, 2'b10);
        b0 = ack0_n; b1 = ack1_n; base = ack0_n + ack1_n;
        req = 2'b11;
        wait_acks(base + 1, "rr_first");
        gap_chk = 1'b1;
        wait_acks(base + 4, "rr_all");
        req = 2'b00;
        gap_chk = 1'b0;
        idle(4);
        check("rr_ack0_count", ack0_n - b0, 2);
        check("rr_ack1_count", ack1_n - b1, 2);

        // Requester 1 pulses for one cycle mid-transfer: never served.
        r0v0 = 12'h5A5; r0v1 = 12'hA5A;
        expect_grant(1'b0, 12'h5A5, 12'hA5A, 2'b01);
        b1 = ack1_n; base = ack0_n + ack1_n;
        req[0] = 1'b1;
        wait_grant("withdraw");
        req[1] = 1'b1;
        idle(1);
        req[1] = 1'b0;
        wait_acks(base + 1, "withdraw");
        req[0] = 1'b0;
        idle(10);
        check("withdraw_ack1_count", ack1_n - b1, 0);

        // Reset in WAIT_DONE: no ack, outputs back to reset values, then requester 1 is served.
        r0v0 = 12'h0AB; r0v1 = 12'h0CD;
        expect_grant(1'b0, 12'h0AB, 12'h0CD, 2'b00);
        b0 = ack0_n;
        req[0] = 1'b1;
        wait_grant("midrst");
        rst = 1'b0; req = 2'b00;
`ifdef DA2_ARBITER_STATS_EN
        st0 = 0; st1 = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        check("midrst_update", int'(upd), 0);
        check("midrst_ack", int'(ack), 0);
        check("midrst_value0", int'(dv0), 0);
        check("midrst_value1", int'(dv1), 0);
        check("midrst_owner", int'(own), 1);
        @(posedge clk); #1 rst = 1'b1;
        r1v0 = 12'hBEE; r1v1 = 12'hCAF;
        expect_grant(1'b1, 12'hBEE, 12'hCAF, 2'b10);
        base = ack0_n + ack1_n;
        req[1] = 1'b1;
        wait_acks(base + 1, "after_rst");
        req[1] = 1'b0;
        idle(4);
        check("midrst_no_ack0", ack0_n - b0, 0);

        // Holdoff instance: three back-to-back grants with requests held.
        req_h = 2'b11;
        c0 = 0;
        while (h_upd_n < 3 && c0 < 300) begin
            @(posedge clk);
            c0++;
        end
        #1 req_h = 2'b00;
        idle(30);
        check("holdoff_updates", h_upd_n, 3);
        check("holdoff_acks", h_ack_n, 3);

`ifdef DA2_ARBITER_STATS_EN
        check("grant_cnt0", int'(gc0), st0);
        check("grant_cnt1", int'(gc1), st1);
`endif
        check("grant_queue_empty", gq.size(), 0);
        check("ack_queue_empty", aq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
